// File: rtl/alu_pipe.sv
// Registered valid/ready ALU with {overflow,negative,zero} flags and an illegal-opcode flag.
// Define ALU_PIPE_MUL_EN to build the BW-step shift-add multiplier (opcode 1000).
module alu_pipe #(
  parameter int BW  = 16,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [BW-1:0]  in_a,
  input  logic [BW-1:0]  in_b,
  input  logic [OPW-1:0] opcode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [BW-1:0]  out,
  output logic [2:0]     flags,
  output logic           illegal
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_AND  = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_OR   = OPW'(4'h3);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(4'h4);
  localparam logic [OPW-1:0] OP_INC  = OPW'(4'h5);
  localparam logic [OPW-1:0] OP_PASS = OPW'(4'h6);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(4'h7);
`ifdef ALU_PIPE_MUL_EN
  localparam logic [OPW-1:0] OP_MUL  = OPW'(4'h8);
  localparam int             CW      = $clog2(BW + 1);

  typedef enum logic [1:0] {S_IDLE, S_RES, S_MUL} state_e;
`else
  typedef enum logic {S_IDLE, S_RES} state_e;
`endif

  state_e        state, state_nxt;
  logic          accept;
  logic          load_alu;
  logic [BW-1:0] alu_res;
  logic          alu_ovf;
  logic          alu_illegal;
  logic [2:0]    alu_flags;

  // Handshake: a held result blocks new work unless it leaves on this same edge.
  assign out_valid = (state == S_RES);
  assign in_ready  = (state == S_IDLE) || ((state == S_RES) && out_ready);
  assign accept    = in_valid && in_ready;

  // Single-cycle datapath, evaluated on the operands presented this cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch can infer a latch.
    alu_res     = '0;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = in_a + in_b;
        alu_ovf = (in_a[BW-1] == in_b[BW-1]) && (alu_res[BW-1] != in_a[BW-1]);
      end
      OP_SUB: begin
        alu_res = in_a - in_b;
        alu_ovf = (in_a[BW-1] != in_b[BW-1]) && (alu_res[BW-1] != in_a[BW-1]);
      end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_INC: begin
        alu_res = in_a + BW'(1);
        alu_ovf = !in_a[BW-1] && alu_res[BW-1];
      end
      OP_PASS: alu_res = in_a;
      OP_NOT:  alu_res = ~in_a;
`ifdef ALU_PIPE_MUL_EN
      // The product comes from the multiplier, never from this path.
      OP_MUL:  alu_res = '0;
`endif
      default: alu_illegal = 1'b1;
    endcase
    alu_flags = alu_illegal ? 3'b001 : {alu_ovf, alu_res[BW-1], alu_res == '0};
  end

`ifdef ALU_PIPE_MUL_EN
  logic            op_is_mul;
  logic            load_mul;
  logic            mul_last;
  logic [2*BW-1:0] acc;
  logic [2*BW-1:0] mcand;
  logic [2*BW-1:0] acc_step;
  logic [BW-1:0]   mplier;
  logic [CW-1:0]   cnt;

  assign op_is_mul = (opcode == OP_MUL);
  assign acc_step  = acc + (mplier[0] ? mcand : '0);
  assign mul_last  = (cnt == CW'(BW - 1));

  // One shift-add step per MUL cycle: multiplicand walks left, multiplier walks right.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the accumulator is plain flops rather than a memory, so it takes the async reset too.
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept && op_is_mul) begin
      acc    <= '0;
      mcand  <= {{BW{1'b0}}, in_a};
      mplier <= in_b;
      cnt    <= '0;
    end else if (state == S_MUL) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    load_alu  = 1'b0;
`ifdef ALU_PIPE_MUL_EN
    load_mul  = 1'b0;
`endif
    case (state)
      S_IDLE, S_RES: begin
        if (accept) begin
`ifdef ALU_PIPE_MUL_EN
          if (op_is_mul) begin
            state_nxt = S_MUL;
          end else begin
            state_nxt = S_RES;
            load_alu  = 1'b1;
          end
`else
          state_nxt = S_RES;
          load_alu  = 1'b1;
`endif
        end else if (out_valid && out_ready) begin
          state_nxt = S_IDLE;
        end
      end
`ifdef ALU_PIPE_MUL_EN
      S_MUL: begin
        if (mul_last) begin
          state_nxt = S_RES;
          load_mul  = 1'b1;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples the values from before the edge.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Result registers only move on a load, which keeps them stable under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out     <= '0;
      flags   <= '0;
      illegal <= 1'b0;
    end else if (load_alu) begin
      out     <= alu_res;
      flags   <= alu_flags;
      illegal <= alu_illegal;
`ifdef ALU_PIPE_MUL_EN
    end else if (load_mul) begin
      out     <= acc_step[BW-1:0];
      flags   <= {|acc_step[2*BW-1:BW], acc_step[BW-1], acc_step[BW-1:0] == '0};
      illegal <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases plus randomized traffic against
// a transaction-level model (signed/unsigned arithmetic and a queue of expected results).
module tb_alu_pipe;

  localparam int     BW   = 16;
  localparam longint SMAX = (longint'(1) <<< (BW - 1)) - 1;
  localparam longint SMIN = -SMAX - 1;
  localparam longint UMAX = (longint'(1) <<< BW) - 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic [3:0]    opcode;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out;
  logic [2:0]    flags;
  logic          illegal;

  alu_pipe #(.BW(BW), .OPW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] out;
    logic [2:0]    flags;
    logic          ill;
    int            t;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   rand_ordy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit is_mul_op(input logic [3:0] op);
`ifdef ALU_PIPE_MUL_EN
    return op == 4'h8;
`else
    return 1'b0;
`endif
  endfunction

  // Expected result straight from the opcode table, using wide integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b);
    exp_t            e;
    longint          sa, sb, sr;
    longint unsigned ua, ub, ur;
    bit              ovf, bad;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    ur = 0; sr = 0; ovf = 0; bad = 0;
    case (op)
      4'h0: begin sr = sa + sb; ur = ua + ub; ovf = (sr > SMAX) || (sr < SMIN); end
      4'h1: begin sr = sa - sb; ur = ua - ub; ovf = (sr > SMAX) || (sr < SMIN); end
      4'h2: ur = ua & ub;
      4'h3: ur = ua | ub;
      4'h4: ur = ua ^ ub;
      4'h5: begin sr = sa + 1; ur = ua + 1; ovf = sr > SMAX; end
      4'h6: ur = ua;
      4'h7: ur = ~ua;
      4'h8: begin
        if (is_mul_op(op)) begin ur = ua * ub; ovf = ur > longint'(UMAX); end
        else bad = 1;
      end
      default: bad = 1;
    endcase
    e.t = 0;
    if (bad) begin
      e.out = '0; e.flags = 3'b001; e.ill = 1'b1;
    end else begin
      e.out   = ur[BW-1:0];
      e.flags = {ovf, e.out[BW-1], e.out == '0};
      e.ill   = 1'b0;
    end
    return e;
  endfunction

  // Compare process: mid-cycle snapshot of what the next rising edge will transfer.
  bit   exp_ov, exp_busy;
  exp_t e_new;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out, 0);
      check("rst_flags", flags, 0);
      check("rst_illegal", illegal, 0);
    end else begin
      exp_ov   = (q.size() > 0) && (q[0].t <= cyc);
      exp_busy = (q.size() > 0) && (q[0].t > cyc);
      check("out_valid", out_valid, exp_ov);
      check("in_ready", in_ready, !exp_busy && !(exp_ov && !out_ready));
      if (exp_ov && out_valid) begin
        check("out", out, q[0].out);
        check("flags", flags, q[0].flags);
        check("illegal", illegal, q[0].ill);
      end
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        e_new   = model(opcode, in_a, in_b);
        e_new.t = cyc + (is_mul_op(opcode) ? BW + 1 : 1);
        q.push_back(e_new);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ordy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called 1 time unit after a rising edge; returns the same way after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b,
                      output int waited);
    waited   = 0;
    in_valid = 1'b1;
    opcode   = op;
    in_a     = a;
    in_b     = b;
    forever begin
      @(negedge clk);
      waited++;
      if (in_ready || waited >= 300) break;
      @(posedge clk); #1;
    end
    check("accept_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int n, output int busy);
    n    = 0;
    busy = 0;
    do begin
      @(negedge clk);
      n++;
      if (!in_ready) busy++;
    end while (!out_valid && n < 100);
  endtask

  task automatic dir_op(input string name, input logic [3:0] op, input logic [BW-1:0] a,
                        input logic [BW-1:0] b, input logic [BW-1:0] x_out, input logic [2:0] x_flags,
                        input logic x_ill, input int x_lat);
    exp_t m;
    int   w, n, busy;
    m = model(op, a, b);
    check({name, "_model_out"}, m.out, x_out);
    check({name, "_model_flags"}, m.flags, x_flags);
    send(op, a, b, w);
    wait_result(n, busy);
    check({name, "_latency"}, n, x_lat);
    check({name, "_busy_cycles"}, busy, x_lat - 1);
    check({name, "_out"}, out, x_out);
    check({name, "_flags"}, flags, x_flags);
    check({name, "_illegal"}, illegal, x_ill);
    @(posedge clk); #1;
  endtask

  function automatic logic [3:0] rand_op();
    int r;
    r = $urandom_range(0, 23);
    if (r < 16) return 4'(r);
    return 4'($urandom_range(0, 8));
  endfunction

  function automatic logic [BW-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 16'h7fff;
      2:       return 16'h8000;
      3:       return 16'hffff;
      4:       return BW'($urandom_range(0, 15));
      default: return BW'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; opcode = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    dir_op("add_ovf",  4'h0, 16'h7fff, 16'h0001, 16'h8000, 3'b110, 1'b0, 1);
    dir_op("add_neg",  4'h0, 16'hffff, 16'hffff, 16'hfffe, 3'b010, 1'b0, 1);
    dir_op("sub_ovf",  4'h1, 16'h7fff, 16'hffff, 16'h8000, 3'b110, 1'b0, 1);
    dir_op("sub_zero", 4'h1, 16'h000f, 16'h000f, 16'h0000, 3'b001, 1'b0, 1);
    dir_op("inc_ovf",  4'h5, 16'h7fff, 16'h0000, 16'h8000, 3'b110, 1'b0, 1);
    dir_op("illegal",  4'hb, 16'h1234, 16'h5678, 16'h0000, 3'b001, 1'b1, 1);
`ifdef ALU_PIPE_MUL_EN
    dir_op("mul_3x5",  4'h8, 16'h0003, 16'h0005, 16'h000f, 3'b000, 1'b0, BW + 1);
    dir_op("mul_ovf",  4'h8, 16'h0100, 16'h0100, 16'h0000, 3'b101, 1'b0, BW + 1);
`else
    dir_op("mul_off",  4'h8, 16'h0003, 16'h0005, 16'h0000, 3'b001, 1'b1, 1);
`endif

    // Four back-to-back ADDs: each must be taken on its first cycle.
    for (int i = 0; i < 4; i++) begin
      send(4'h0, BW'(16'h0100 * (i + 1)), 16'h0011, w);
      check("stream_wait", w, 1);
    end
    repeat (2) @(posedge clk);
    #1;

    // Hold a result for three cycles with the next operation waiting upstream.
    out_ready = 1'b0;
    send(4'h0, 16'h1234, 16'h1111, w);
    in_valid = 1'b1; opcode = 4'h1; in_a = 16'h2345; in_b = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out", out, 16'h2345);
      check("bp_flags", flags, 3'b000);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    dir_op("bp_next_sub", 4'h1, 16'h2345, 16'h1111, 16'h1234, 3'b000, 1'b0, 1);

    // Asynchronous reset in the middle of work.
`ifdef ALU_PIPE_MUL_EN
    send(4'h8, 16'h1234, 16'h0042, w);
    repeat (7) @(posedge clk);
    #1;
`else
    send(4'h0, 16'h1234, 16'h0042, w);
`endif
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out", out, 0);
    check("async_rst_flags", flags, 0);
    check("async_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    dir_op("post_rst_add", 4'h0, 16'h0002, 16'h0002, 16'h0004, 3'b000, 1'b0, 1);

    // Randomized traffic with random gaps and random downstream stalls.
    rand_ordy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
      send(rand_op(), rand_operand(), rand_operand(), w);
    end
    rand_ordy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    repeat (BW + 4) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
